// File: rtl/led_shifter_pkg.sv
// ============================================================================
// led_shifter_pkg : shared mode/direction encodings for the LED shifter.
// Revision 1.0
// ============================================================================
`default_nettype none

package led_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL   = 2'd0,
    MODE_ROTATE   = 2'd1,
    MODE_PINGPONG = 2'd2
  } mode_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // The unused encoding 3 falls back to MANUAL.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_MANUAL:   next_mode = MODE_ROTATE;
      MODE_ROTATE:   next_mode = MODE_PINGPONG;
      default:       next_mode = MODE_MANUAL;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_shifter_n_tick.sv
// ============================================================================
// tick_generator : one-cycle tick every TICK_DIV enabled clk cycles.
// Revision 1.0
// ============================================================================
`default_nettype none

module tick_generator #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic async_reset_debounced,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned         c_CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(TICK_DIV - 1);

  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count_next;
  logic               w_at_last;

  assign w_at_last = (r_count == c_CNT_LAST);

  // Clear, disable and wrap all return the counter to zero.
  always_comb begin
    w_count_next = '0;
    if (!clear && enable && !w_at_last)
      w_count_next = r_count + c_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge async_reset_debounced) begin
    if (!async_reset_debounced)
      r_count <= '0;
    else
      r_count <= w_count_next;
  end

  assign tick = enable && !clear && w_at_last;

endmodule

`default_nettype wire

// File: rtl/led_shifter_n.sv
// ============================================================================
// led_shifter_n : button-driven LED pattern shifter with MANUAL/ROTATE/PINGPONG.
// Revision 1.0
// ============================================================================
`default_nettype none

module led_shifter_n
  import led_shifter_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      TICK_DIV      = 50_000_000,
  parameter logic [WIDTH-1:0] RESET_PATTERN = '0
) (
  input  logic             clk,
  input  logic             async_reset_debounced,
  input  logic             btn_0_re,
  input  logic             btn_1_re,
  input  logic             btn_dir_re,
  input  logic             btn_mode_re,
  output logic [WIDTH-1:0] led_output,
  output logic [1:0]       mode_output,
  output logic             dir_output
);

  localparam int unsigned          c_STEP_W    = $clog2(WIDTH);
  localparam logic [c_STEP_W-1:0]  c_STEP_LAST = c_STEP_W'(WIDTH - 1);

  logic [WIDTH-1:0]    r_pattern, w_pattern_next;
  mode_t               r_mode,    w_mode_next;
  logic                r_dir,     w_dir_next;
  logic [c_STEP_W-1:0] r_step,    w_step_next;

  logic                w_mode_valid;
  logic                w_mode_change;
  logic                w_auto;
  logic                w_tick;
  logic                w_shift_bit;
  logic [WIDTH-1:0]    w_rotated;
  logic [c_STEP_W-1:0] w_step_inc;

  assign w_mode_valid  = (r_mode == MODE_MANUAL) || (r_mode == MODE_ROTATE) ||
                         (r_mode == MODE_PINGPONG);
  assign w_mode_change = btn_mode_re || !w_mode_valid;
  assign w_auto        = (r_mode == MODE_ROTATE) || (r_mode == MODE_PINGPONG);
  assign w_shift_bit   = !btn_0_re;
  assign w_step_inc    = r_step + c_STEP_W'(1);
  assign w_rotated     = (r_dir == DIR_LEFT) ? {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]}
                                             : {r_pattern[0], r_pattern[WIDTH-1:1]};

  // A mode change clears the divider and suppresses the coincident tick.
  tick_generator #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk                   (clk),
    .async_reset_debounced (async_reset_debounced),
    .enable                (w_auto),
    .clear                 (w_mode_change),
    .tick                  (w_tick)
  );

  always_comb begin
    w_pattern_next = r_pattern;
    w_mode_next    = r_mode;
    w_dir_next     = r_dir;
    w_step_next    = r_step;

    case (r_mode)
      MODE_MANUAL: begin
        if (btn_0_re || btn_1_re)
          w_pattern_next = (r_dir == DIR_LEFT) ? {r_pattern[WIDTH-2:0], w_shift_bit}
                                               : {w_shift_bit, r_pattern[WIDTH-1:1]};
      end
      MODE_ROTATE: begin
        if (w_tick)
          w_pattern_next = w_rotated;
      end
      MODE_PINGPONG: begin
        if (w_tick) begin
          w_pattern_next = w_rotated;
          if (w_step_inc == c_STEP_LAST) begin
            w_dir_next  = ~r_dir;
            w_step_next = '0;
          end else begin
            w_step_next = w_step_inc;
          end
        end
      end
      default: ;
    endcase

    // Overrides the end-of-sweep toggle so dir flips exactly once.
    if (btn_dir_re) begin
      w_dir_next = ~r_dir;
      if (r_mode == MODE_PINGPONG)
        w_step_next = '0;
    end

    if (w_mode_change) begin
      w_mode_next = next_mode(r_mode);
      w_step_next = '0;
    end
  end

  always_ff @(posedge clk or negedge async_reset_debounced) begin
    if (!async_reset_debounced) begin
      r_pattern <= RESET_PATTERN;
      r_mode    <= MODE_MANUAL;
      r_dir     <= DIR_LEFT;
      r_step    <= '0;
    end else begin
      r_pattern <= w_pattern_next;
      r_mode    <= w_mode_next;
      r_dir     <= w_dir_next;
      r_step    <= w_step_next;
    end
  end

  assign led_output  = r_pattern;
  assign mode_output = r_mode;
  assign dir_output  = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_led_shifter_n.sv
// ============================================================================
// tb_led_shifter_n : directed bench for led_shifter_n (WIDTH 8, TICK_DIV 4).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_led_shifter_n;

  logic       clk = 1'b0;
  logic       async_reset_debounced = 1'b1;
  logic       btn_0_re = 1'b0;
  logic       btn_1_re = 1'b0;
  logic       btn_dir_re = 1'b0;
  logic       btn_mode_re = 1'b0;
  logic [7:0] led_output;
  logic [1:0] mode_output;
  logic       dir_output;

  int checks = 0;
  int errors = 0;

  led_shifter_n #(
    .WIDTH         (8),
    .TICK_DIV      (4),
    .RESET_PATTERN (8'h81)
  ) dut (
    .clk                   (clk),
    .async_reset_debounced (async_reset_debounced),
    .btn_0_re              (btn_0_re),
    .btn_1_re              (btn_1_re),
    .btn_dir_re            (btn_dir_re),
    .btn_mode_re           (btn_mode_re),
    .led_output            (led_output),
    .mode_output           (mode_output),
    .dir_output            (dir_output)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic b0, input logic b1, input logic bd, input logic bm);
    btn_0_re = b0; btn_1_re = b1; btn_dir_re = bd; btn_mode_re = bm;
    cyc(1);
    btn_0_re = 1'b0; btn_1_re = 1'b0; btn_dir_re = 1'b0; btn_mode_re = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] led, input logic [1:0] mode,
                     input logic dir);
    checks++;
    assert ({led_output, mode_output, dir_output} === {led, mode, dir})
    else begin
      errors++;
      $error("FAIL %s: observed led=%h mode=%0d dir=%0b expected led=%h mode=%0d dir=%0b",
             tag, led_output, mode_output, dir_output, led, mode, dir);
    end
  endtask

  initial begin
    #2 async_reset_debounced = 1'b0;
    #1 chk("reset_async", 8'h81, 2'd0, 1'b0);
    cyc(1);
    async_reset_debounced = 1'b1;

    // MANUAL inserts
    pulse(0, 1, 0, 0); chk("man_ins1_a", 8'h03, 2'd0, 1'b0);
    pulse(0, 1, 0, 0); chk("man_ins1_b", 8'h07, 2'd0, 1'b0);
    pulse(1, 0, 0, 0); chk("man_ins0",   8'h0E, 2'd0, 1'b0);
    pulse(0, 0, 1, 0); chk("man_dir",    8'h0E, 2'd0, 1'b1);
    pulse(0, 1, 0, 0); chk("man_right1", 8'h87, 2'd0, 1'b1);
    pulse(1, 1, 0, 0); chk("man_both",   8'h43, 2'd0, 1'b1);
    pulse(0, 1, 1, 0); chk("man_dir_shift", 8'hA1, 2'd0, 1'b0);

    // Mode change with shift, then ROTATE
    pulse(1, 0, 0, 1); chk("mode_shift", 8'h42, 2'd1, 1'b0);
    cyc(3);            chk("rot_hold",   8'h42, 2'd1, 1'b0);
    cyc(1);            chk("rot_tick1",  8'h84, 2'd1, 1'b0);
    pulse(1, 0, 0, 0); chk("rot_ign0",   8'h84, 2'd1, 1'b0);
    pulse(0, 1, 0, 0); chk("rot_ign1",   8'h84, 2'd1, 1'b0);
    cyc(1);            chk("rot_hold2",  8'h84, 2'd1, 1'b0);
    cyc(1);            chk("rot_tick2",  8'h09, 2'd1, 1'b0);
    cyc(3);
    pulse(0, 0, 1, 0); chk("rot_dir_on_tick", 8'h12, 2'd1, 1'b1);
    cyc(4);            chk("rot_right",  8'h09, 2'd1, 1'b1);
    cyc(3);
    pulse(0, 0, 0, 1); chk("mode_on_tick", 8'h09, 2'd2, 1'b1);
    cyc(3);            chk("pp_hold",    8'h09, 2'd2, 1'b1);
    cyc(1);            chk("pp_first",   8'h84, 2'd2, 1'b1);

    // Back to MANUAL, load 0x01
    pulse(0, 0, 0, 1); chk("to_manual",  8'h84, 2'd0, 1'b1);
    pulse(0, 0, 1, 0); chk("dir_left",   8'h84, 2'd0, 1'b0);
    repeat (8) pulse(1, 0, 0, 0);
    chk("clear_zeros", 8'h00, 2'd0, 1'b0);
    pulse(0, 1, 0, 0); chk("load_one",   8'h01, 2'd0, 1'b0);

    // PINGPONG sweeps; second mode press lands mid-count
    pulse(0, 0, 0, 1); chk("to_rotate",  8'h01, 2'd1, 1'b0);
    pulse(0, 0, 0, 1); chk("to_pp",      8'h01, 2'd2, 1'b0);
    cyc(3);            chk("pp_clear_cnt", 8'h01, 2'd2, 1'b0);
    cyc(1);            chk("pp_t1",      8'h02, 2'd2, 1'b0);
    cyc(12);           chk("pp_t4",      8'h10, 2'd2, 1'b0);
    cyc(12);           chk("pp_t7_rev",  8'h80, 2'd2, 1'b1);
    cyc(24);           chk("pp_t13",     8'h02, 2'd2, 1'b1);
    cyc(3);
    pulse(0, 0, 1, 0); chk("pp_end_dir", 8'h01, 2'd2, 1'b0);
    cyc(24);           chk("pp_t20",     8'h40, 2'd2, 1'b0);
    cyc(4);            chk("pp_t21_rev", 8'h80, 2'd2, 1'b1);

    // Asynchronous reset mid-count
    cyc(2);
    #2 async_reset_debounced = 1'b0;
    #1 chk("reset_mid", 8'h81, 2'd0, 1'b0);
    #2 async_reset_debounced = 1'b1;
    cyc(6);            chk("post_reset_idle", 8'h81, 2'd0, 1'b0);
    pulse(0, 0, 0, 1); chk("post_reset_rot",  8'h81, 2'd1, 1'b0);
    cyc(3);            chk("post_reset_hold", 8'h81, 2'd1, 1'b0);
    cyc(1);            chk("post_reset_tick", 8'h03, 2'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_shifter_n.md
# led_shifter_n

Parametrised LED pattern shifter: a WIDTH-bit pattern register driven by debounced, rising-edge-detected push-buttons, with selectable shift direction and three modes. MANUAL inserts 0/1 per button press; ROTATE and PINGPONG step the pattern automatically on a divided clock tick. It sits between the button edge detectors and the board LED bank, next to the existing 8-bit shifter it supersedes.

## Interface
- WIDTH, 8: pattern/LED width. Legal range is ≥2.
- TICK_DIV, 50_000_000: clk cycles per auto-step tick. Legal range is ≥1.
- RESET_PATTERN, {WIDTH{1'b0}}: pattern loaded on reset.

Ports:
- clk  in  1  system clock.
- async_reset_debounced  in  1  reset, asynchronous, active-low.
- btn_0_re  in  1  one-cycle pulse: shift in 0.
- btn_1_re  in  1  one-cycle pulse: shift in 1.
- btn_dir_re  in  1  one-cycle pulse: toggle direction.
- btn_mode_re  in  1  one-cycle pulse: advance mode.
- led_output  out  WIDTH  pattern register.
- mode_output  out  2  current mode: 0 MANUAL, 1 ROTATE, 2 PINGPONG.
- dir_output  out  1  0 = left (toward MSB), 1 = right (toward LSB).

## Operation
- State: `pattern[WIDTH]`, `mode[2]`, `dir`, tick counter `[$clog2(TICK_DIV)]`, step counter `[$clog2(WIDTH)]`.
- **Reset values:** `pattern` = RESET_PATTERN, `mode` = MANUAL, `dir` = 0, both counters = 0.
- **Mode advance:** `btn_mode_re` cycles MANUAL→ROTATE→PINGPONG→MANUAL. Encoding 3 is unreachable; if it is ever seen, the next cycle goes to MANUAL. Any mode change clears both counters.
- **Shift in MANUAL:**
  - `btn_0_re` inserts 0; `btn_1_re` inserts 1. If both pulse in the same cycle, `btn_0_re` wins.
  - With `dir` = 0: `pattern <= {pattern[WIDTH-2:0], b}`.
  - With `dir` = 1: `pattern <= {b, pattern[WIDTH-1:1]}`.
- **Auto modes:** `btn_0_re` and `btn_1_re` are ignored in ROTATE and PINGPONG.
- **Tick counter:**
  - Runs only in ROTATE and PINGPONG; it is held at 0 in MANUAL.
  - Counts 0..TICK_DIV-1.
  - `tick` is asserted while count == TICK_DIV-1, then the counter wraps to 0.
- **ROTATE:** on each tick, rotate by one in `dir`. Left: `{p[WIDTH-2:0], p[WIDTH-1]}`. Right: `{p[0], p[WIDTH-1:1]}`.
- **PINGPONG:** on each tick, rotate as in ROTATE and increment the step counter. When the incremented value equals WIDTH-1, toggle `dir` and clear the step counter.
- **btn_dir_re:** toggles `dir` in every mode. In PINGPONG it also clears the step counter.
- **Simultaneous events (required precedence):**
  - `btn_mode_re` together with a tick: the mode change is taken and no rotation occurs.
  - `btn_mode_re` together with a MANUAL shift: the mode change and the shift both apply, using the old mode's semantics. The shift happens because the current mode is MANUAL.
  - `btn_dir_re` together with a shift or tick: the shift/rotation uses the old `dir`; `dir` toggles at the same edge.
  - PINGPONG end-of-sweep toggle together with `btn_dir_re`: `btn_dir_re` wins. `dir` toggles exactly once and the step counter clears.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous); any partial tick count is discarded.

## Timing
- All outputs come directly from registers; there is no combinational path from input to output.
- A button pulse sampled at edge N updates the outputs after edge N (one-cycle latency).
- Entering ROTATE/PINGPONG at edge E: the first rotation is at edge E+TICK_DIV, then every TICK_DIV cycles.
- TICK_DIV = 1: a tick occurs every cycle in auto modes.
- PINGPONG period: the direction reverses every WIDTH-1 ticks. A single lit bit sweeps end to end without wrapping, provided it starts at an end bit.

## Structure
- Package `led_shifter_pkg`:
  - `typedef enum logic [1:0] {MODE_MANUAL, MODE_ROTATE, MODE_PINGPONG} mode_t`.
  - Constants `DIR_LEFT = 1'b0`, `DIR_RIGHT = 1'b1`.
- Sub-module `tick_generator`:
  - Parameter TICK_DIV.
  - Inputs: `clk`, `async_reset_debounced`, `enable`, `clear`. Output: `tick`.
  - `clear` takes priority over `enable`.
- The top level holds the mode/dir/pattern/step registers as a next-state combinational block plus a register block.

## Test plan
(WIDTH = 8, TICK_DIV = 4, RESET_PATTERN = 0 unless noted)
- **MANUAL insert:** reset; `btn_1_re`, `btn_1_re`, `btn_0_re` → led 0x01, 0x03, 0x06. Then `btn_dir_re` and `btn_1_re` → 0x83. Both `btn_0_re` and `btn_1_re` in one cycle → a 0 is inserted.
- **ROTATE:** RESET_PATTERN = 0x81; `btn_mode_re` → mode 1.
  - Led stays 0x81 for 3 cycles and becomes 0x03 on the 4th edge, then 0x06.
  - After `btn_dir_re`, each tick rotates right.
- **PINGPONG:** pattern 0x01, mode 2, `dir` 0.
  - After 7 ticks led = 0x80 and `dir` = 1.
  - After 7 more ticks led = 0x01 and `dir` = 0.
- **Collisions:**
  - `btn_mode_re` on a tick cycle → no rotation, counters cleared.
  - `btn_dir_re` on a tick → rotation uses the old `dir`, `dir` toggles once.
  - `btn_dir_re` on the PINGPONG end-of-sweep tick → `dir` toggles only once.
- **Auto-mode ignore:** in ROTATE, `btn_0_re` and `btn_1_re` → pattern unchanged except for ticks.
- **Reset mid-operation:** assert reset mid-count in PINGPONG → outputs become RESET_PATTERN/0/0 asynchronously. After release, MANUAL mode, and no tick appears.
